// File: rtl/leglite_fetch_if.sv
// rtl/leglite_fetch_if.sv - LEGLite fetch-stage bus: imem req/ack, decode valid/ready, branch redirect
interface leglite_fetch_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               instr_ready;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid,
      input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid,
      output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/leglite_fetch.sv
// rtl/leglite_fetch.sv - LEGLite instruction fetch stage (PC, multi-cycle imem, redirect); FETCH_PERF_EN adds perf counters
module leglite_fetch #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 2
) (
   input  logic                clock,
   input  logic                reset,
   leglite_fetch_if.master     bus
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]         perf_fetched,
   output logic [15:0]         perf_flushed
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t             state, state_n;
   logic [PC_W-1:0]    pc, pc_n;
   logic [PC_W-1:0]    pend_pc, pend_pc_n;
   logic               pend, pend_n;
   logic [INSTR_W-1:0] instr_q, instr_n;
   logic [PC_W-1:0]    instr_pc_q, instr_pc_n;
   logic               valid_q, valid_n;

   assign bus.imem_req    = (state == REQ);
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         pend       <= 1'b0;
         pend_pc    <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         pend       <= pend_n;
         pend_pc    <= pend_pc_n;
         instr_q    <= instr_n;
         instr_pc_q <= instr_pc_n;
         valid_q    <= valid_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      pend_n     = pend;
      pend_pc_n  = pend_pc;
      instr_n    = instr_q;
      instr_pc_n = instr_pc_q;
      valid_n    = valid_q;
      case (state)
         IDLE: begin
            if (bus.redirect) pc_n = bus.redirect_pc;
            valid_n = 1'b0;
            state_n = REQ;
         end
         REQ: begin
            if (bus.imem_ack) begin
               // A redirect arriving with the ack beats any older pending target.
               if (bus.redirect) begin
                  pc_n   = bus.redirect_pc;
                  pend_n = 1'b0;
               end else if (pend) begin
                  pc_n   = pend_pc;
                  pend_n = 1'b0;
               end else begin
                  instr_n    = bus.imem_rdata;
                  instr_pc_n = pc;
                  pc_n       = pc + PC_W'(PC_STEP);
                  valid_n    = 1'b1;
                  state_n    = HOLD;
               end
            end else if (bus.redirect) begin
               // Address is locked while the request is in flight; remember the target.
               pend_n    = 1'b1;
               pend_pc_n = bus.redirect_pc;
            end
         end
         HOLD: begin
            if (bus.redirect) begin
               pc_n    = bus.redirect_pc;
               valid_n = 1'b0;
               state_n = REQ;
            end else if (bus.instr_ready) begin
               valid_n = 1'b0;
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef FETCH_PERF_EN
   logic fetch_evt, flush_evt;

   assign fetch_evt = (state == HOLD) && bus.instr_ready && !bus.redirect;
   assign flush_evt = ((state == REQ) && bus.imem_ack && (pend || bus.redirect)) ||
                      ((state == HOLD) && bus.redirect);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (fetch_evt && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
         if (flush_evt && perf_flushed != 16'hFFFF) perf_flushed <= perf_flushed + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_leglite_fetch.sv
// tb/tb_leglite_fetch.sv - directed bench for leglite_fetch with a fixed-latency instruction memory
module tb_leglite_fetch;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   mem_lat  = 1;
   int   wait_cnt = 0;

   leglite_fetch_if #(.PC_W(16), .INSTR_W(16)) bus ();

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched, perf_flushed;
`endif

   leglite_fetch dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_perf(input string tag, input int f, input int fl);
`ifdef FETCH_PERF_EN
      check({tag, "_perf_fetched"}, 32'(perf_fetched), 32'(f));
      check({tag, "_perf_flushed"}, 32'(perf_flushed), 32'(fl));
`endif
   endtask

   // Memory: acks mem_lat negedges into each request with a one-cycle pulse.
   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clock);
         bus.imem_ack = 1'b0;
         if (bus.imem_req === 1'b1) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem_word(bus.imem_addr);
               wait_cnt       = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic do_reset(input int lat);
      reset           = 1'b0;
      bus.instr_ready = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      repeat (2) @(negedge clock);
      check("rst_req",   32'(bus.imem_req), 0);
      check("rst_addr",  32'(bus.imem_addr), 0);
      check("rst_valid", 32'(bus.instr_valid), 0);
      check("rst_instr", 32'(bus.instr), 0);
      check("rst_pc",    32'(bus.instr_pc), 0);
      mem_lat = lat;
      reset   = 1'b1;
      #1;
      check("idle_no_req", 32'(bus.imem_req), 0);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_req"}, 32'(bus.imem_req), 1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (bus.instr_valid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_valid"}, 32'(bus.instr_valid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // 1: sequential fetch, single-cycle ack, decode always ready
      do_reset(1);
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_req("t1");
         check("t1_addr", 32'(bus.imem_addr), 32'(2 * k));
         wait_valid("t1");
         check("t1_ipc", 32'(bus.instr_pc), 32'(2 * k));
         check("t1_instr", 32'(bus.instr), 32'(mem_word(16'(2 * k))));
      end
      @(negedge clock);
      check_perf("t1", 4, 0);

      // 2: decode stalls five cycles on the first instruction
      do_reset(1);
      wait_valid("t2");
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("t2_hold_valid", 32'(bus.instr_valid), 1);
         check("t2_hold_ipc",   32'(bus.instr_pc), 0);
         check("t2_hold_instr", 32'(bus.instr), 32'(mem_word(16'h0000)));
         check("t2_hold_req",   32'(bus.imem_req), 0);
      end
      bus.instr_ready = 1'b1;
      @(negedge clock);
      check("t2_rel_valid", 32'(bus.instr_valid), 0);
      check("t2_rel_req",   32'(bus.imem_req), 1);
      check("t2_rel_addr",  32'(bus.imem_addr), 32'h0002);
      wait_valid("t2b");
      check("t2_ipc2", 32'(bus.instr_pc), 32'h0002);
      @(negedge clock);
      bus.instr_ready = 1'b0;
      wait_valid("t3");
      check("t3_ipc4", 32'(bus.instr_pc), 32'h0004);

      // 3: redirect from HOLD drops the held instruction even with ready high
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0040;
      bus.instr_ready = 1'b1;
      @(negedge clock);
      bus.redirect = 1'b0;
      check("t3_drop_valid", 32'(bus.instr_valid), 0);
      check("t3_req",        32'(bus.imem_req), 1);
      check("t3_addr",       32'(bus.imem_addr), 32'h0040);
      wait_valid("t3b");
      check("t3_ipc",   32'(bus.instr_pc), 32'h0040);
      check("t3_instr", 32'(bus.instr), 32'(mem_word(16'h0040)));
      @(negedge clock);
      check_perf("t23", 3, 1);

      // 4: two redirects during a 4-cycle memory wait; last one wins
      do_reset(4);
      bus.instr_ready = 1'b1;
      wait_req("t4");
      check("t4_addr_c1", 32'(bus.imem_addr), 0);
      @(negedge clock);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0100;
      @(negedge clock);
      check("t4_addr_c3", 32'(bus.imem_addr), 0);
      bus.redirect_pc = 16'h0200;
      @(negedge clock);
      bus.redirect = 1'b0;
      check("t4_addr_c4", 32'(bus.imem_addr), 0);
      check("t4_req_c4",  32'(bus.imem_req), 1);
      @(negedge clock);
      check("t4_discard_valid", 32'(bus.instr_valid), 0);
      check("t4_new_req",       32'(bus.imem_req), 1);
      check("t4_new_addr",      32'(bus.imem_addr), 32'h0200);
      wait_valid("t4");
      check("t4_ipc",   32'(bus.instr_pc), 32'h0200);
      check("t4_instr", 32'(bus.instr), 32'(mem_word(16'h0200)));
      @(negedge clock);
      check_perf("t4", 1, 1);

      // 4b: pending redirect, then a newer redirect coinciding with the ack
      do_reset(2);
      bus.instr_ready = 1'b1;
      wait_req("t4b");
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0300;
      @(negedge clock);
      bus.redirect_pc = 16'h0400;
      @(negedge clock);
      bus.redirect = 1'b0;
      check("t4b_valid", 32'(bus.instr_valid), 0);
      check("t4b_addr",  32'(bus.imem_addr), 32'h0400);
      wait_valid("t4b");
      check("t4b_ipc", 32'(bus.instr_pc), 32'h0400);
      @(negedge clock);
      check_perf("t4b", 1, 1);

      // 5: redirect in the same cycle as the ack
      do_reset(1);
      bus.instr_ready = 1'b1;
      wait_req("t5");
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0010;
      @(negedge clock);
      bus.redirect = 1'b0;
      check("t5_valid", 32'(bus.instr_valid), 0);
      check("t5_req",   32'(bus.imem_req), 1);
      check("t5_addr",  32'(bus.imem_addr), 32'h0010);
      wait_valid("t5");
      check("t5_ipc",   32'(bus.instr_pc), 32'h0010);
      check("t5_instr", 32'(bus.instr), 32'(mem_word(16'h0010)));
      @(negedge clock);
      check_perf("t5", 1, 1);

      // 6: PC wraps from 0xFFFE to 0x0000
      do_reset(1);
      wait_valid("t6a");
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFE;
      @(negedge clock);
      bus.redirect = 1'b0;
      check("t6_addr_top", 32'(bus.imem_addr), 32'hFFFE);
      bus.instr_ready = 1'b1;
      wait_valid("t6b");
      check("t6_ipc", 32'(bus.instr_pc), 32'hFFFE);
      @(negedge clock);
      check("t6_wrap_req",  32'(bus.imem_req), 1);
      check("t6_wrap_addr", 32'(bus.imem_addr), 32'h0000);
      check_perf("t6", 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
